bnn_host_loader: RTL and testbench

//  Host-side transmitter for the BNN accelerator's bit-serial load interface.

---
 rtl/bnn_host_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_bnn_host_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_host_loader.sv
// bnn_host_loader: host-side transmitter for the BNN accelerator's bit-serial
// load port. Pixel and weight bytes arrive on valid/ready streams. They are
// serialized LSB-first onto d_in_p_o/d_in_w_o, and bit_valid_o marks each
// valid bit. The block then waits for the accelerator's done and returns the
// 4-bit answer on a valid/ready result port.
// Optional feature: define BNN_LOADER_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles. On timeout the result is 4'hF with result_err_o set.
module bnn_host_loader #(
  parameter int PIX_BITS = 784,
  parameter int WGT_BITS = 2320,
  parameter int TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] pix_data_i,
  input  logic       pix_valid_i,
  output logic       pix_ready_o,
  input  logic [7:0] wgt_data_i,
  input  logic       wgt_valid_i,
  output logic       wgt_ready_o,
  output logic       busy_o,
  output logic       mode_o,
  output logic       d_in_p_o,
  output logic       d_in_w_o,
  output logic       bit_valid_o,
  input  logic [3:0] answer_i,
  input  logic       result_done_i,
  output logic [3:0] result_o,
  output logic       result_err_o,
  output logic       result_valid_o,
  input  logic       result_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESULT} state_e;

  localparam int            CW        = $clog2(WGT_BITS + 1);
  localparam logic [CW-1:0] PIX_BYTES = CW'(PIX_BITS / 8);
  localparam logic [CW-1:0] WGT_BYTES = CW'(WGT_BITS / 8);
  localparam logic [CW-1:0] PIX_ALL   = CW'(PIX_BITS);
  localparam logic [CW-1:0] WGT_LAST  = CW'(WGT_BITS - 1);

  state_e        state_q, state_d;
  logic [7:0]    pix_sr_q, pix_sr_d, wgt_sr_q, wgt_sr_d;
  logic [3:0]    pix_fill_q, pix_fill_d, wgt_fill_q, wgt_fill_d;
  logic [CW-1:0] pix_bytes_q, pix_bytes_d, wgt_bytes_q, wgt_bytes_d;
  logic [CW-1:0] pix_sent_q, pix_sent_d, wgt_sent_q, wgt_sent_d;
  logic          d_in_p_q, d_in_p_d, d_in_w_q, d_in_w_d, bit_valid_q, bit_valid_d;
  logic          mode_q, mode_d, busy_q, busy_d;
  logic [3:0]    result_q, result_d;
  logic          result_err_q, result_err_d, result_valid_q, result_valid_d;

  logic frame_start, pix_left, wgt_left, pix_done, pix_bypass, wgt_bypass;
  logic beat, last_beat, pix_acc, wgt_acc, pix_bit, wgt_bit, tmo_hit;

  // Stream bookkeeping. An empty shift register can forward the byte being
  // accepted straight to the serial line. This keeps the stream bubble-free.
  assign frame_start = (state_q == S_IDLE) && start_i;
  assign pix_left    = (state_q == S_LOAD) && (pix_bytes_q != PIX_BYTES);
  assign wgt_left    = (state_q == S_LOAD) && (wgt_bytes_q != WGT_BYTES);
  assign pix_done    = (pix_sent_q == PIX_ALL);
  assign pix_bypass  = pix_left && (pix_fill_q == 4'd0) && pix_valid_i;
  assign wgt_bypass  = wgt_left && (wgt_fill_q == 4'd0) && wgt_valid_i;
  assign beat        = (state_q == S_LOAD)
                     && ((wgt_fill_q != 4'd0) || wgt_bypass)
                     && ((pix_fill_q != 4'd0) || pix_bypass || pix_done);
  assign last_beat   = beat && (wgt_sent_q == WGT_LAST);
  assign pix_ready_o = pix_left && ((pix_fill_q == 4'd0) || ((pix_fill_q == 4'd1) && beat));
  assign wgt_ready_o = wgt_left && ((wgt_fill_q == 4'd0) || ((wgt_fill_q == 4'd1) && beat));
  assign pix_acc     = pix_ready_o && pix_valid_i;
  assign wgt_acc     = wgt_ready_o && wgt_valid_i;
  assign pix_bit     = (pix_fill_q != 4'd0) ? pix_sr_q[0] : (pix_bypass & pix_data_i[0]);
  assign wgt_bit     = (wgt_fill_q != 4'd0) ? wgt_sr_q[0] : wgt_data_i[0];

`ifdef BNN_LOADER_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Count the cycles spent in WAIT. The count restarts each time WAIT is entered.
  always_comb tmo_d = (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TMO_LAST);
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A start_i pulse outside IDLE has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i)                           state_d = S_LOAD;
      S_LOAD:   if (last_beat)                         state_d = S_WAIT;
      S_WAIT:   if (result_done_i || tmo_hit)          state_d = S_RESULT;
      S_RESULT: if (result_valid_q && result_ready_i)  state_d = S_IDLE;
      default:                                         state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. These are derived from the state and
  // the stream handshakes.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pix_sr_d       = pix_sr_q;
    pix_fill_d     = pix_fill_q;
    wgt_sr_d       = wgt_sr_q;
    wgt_fill_d     = wgt_fill_q;
    pix_bytes_d    = pix_bytes_q;
    wgt_bytes_d    = wgt_bytes_q;
    pix_sent_d     = pix_sent_q;
    wgt_sent_d     = wgt_sent_q;
    d_in_p_d       = d_in_p_q;
    d_in_w_d       = d_in_w_q;
    bit_valid_d    = beat;
    result_d       = result_q;
    result_err_d   = result_err_q;
    result_valid_d = result_valid_q;

    if (frame_start) begin
      pix_sr_d    = '0;
      pix_fill_d  = '0;
      wgt_sr_d    = '0;
      wgt_fill_d  = '0;
      pix_bytes_d = '0;
      wgt_bytes_d = '0;
      pix_sent_d  = '0;
      wgt_sent_d  = '0;
    end else begin
      if (pix_acc) begin
        pix_bytes_d = pix_bytes_q + 1'b1;
        if ((pix_fill_q == 4'd0) && beat) begin
          pix_sr_d   = {1'b0, pix_data_i[7:1]};
          pix_fill_d = 4'd7;
        end else begin
          pix_sr_d   = pix_data_i;
          pix_fill_d = 4'd8;
        end
      end else if (beat && (pix_fill_q != 4'd0)) begin
        pix_sr_d   = {1'b0, pix_sr_q[7:1]};
        pix_fill_d = pix_fill_q - 4'd1;
      end

      if (wgt_acc) begin
        wgt_bytes_d = wgt_bytes_q + 1'b1;
        if ((wgt_fill_q == 4'd0) && beat) begin
          wgt_sr_d   = {1'b0, wgt_data_i[7:1]};
          wgt_fill_d = 4'd7;
        end else begin
          wgt_sr_d   = wgt_data_i;
          wgt_fill_d = 4'd8;
        end
      end else if (beat && (wgt_fill_q != 4'd0)) begin
        wgt_sr_d   = {1'b0, wgt_sr_q[7:1]};
        wgt_fill_d = wgt_fill_q - 4'd1;
      end

      if (beat) begin
        d_in_p_d   = pix_bit;
        d_in_w_d   = wgt_bit;
        wgt_sent_d = wgt_sent_q + 1'b1;
        if (!pix_done) pix_sent_d = pix_sent_q + 1'b1;
      end
    end

    if (state_q == S_WAIT) begin
      if (result_done_i) begin
        result_d       = answer_i;
        result_err_d   = 1'b0;
        result_valid_d = 1'b1;
      end else if (tmo_hit) begin
        result_d       = 4'hF;
        result_err_d   = 1'b1;
        result_valid_d = 1'b1;
      end
    end
    if ((state_q == S_RESULT) && result_valid_q && result_ready_i) begin
      result_valid_d = 1'b0;
      result_err_d   = 1'b0;
    end

    mode_d = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      pix_sr_q       <= '0;
      pix_fill_q     <= '0;
      wgt_sr_q       <= '0;
      wgt_fill_q     <= '0;
      pix_bytes_q    <= '0;
      wgt_bytes_q    <= '0;
      pix_sent_q     <= '0;
      wgt_sent_q     <= '0;
      d_in_p_q       <= 1'b0;
      d_in_w_q       <= 1'b0;
      bit_valid_q    <= 1'b0;
      mode_q         <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_err_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      pix_sr_q       <= pix_sr_d;
      pix_fill_q     <= pix_fill_d;
      wgt_sr_q       <= wgt_sr_d;
      wgt_fill_q     <= wgt_fill_d;
      pix_bytes_q    <= pix_bytes_d;
      wgt_bytes_q    <= wgt_bytes_d;
      pix_sent_q     <= pix_sent_d;
      wgt_sent_q     <= wgt_sent_d;
      d_in_p_q       <= d_in_p_d;
      d_in_w_q       <= d_in_w_d;
      bit_valid_q    <= bit_valid_d;
      mode_q         <= mode_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_err_q   <= result_err_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy_o         = busy_q;
  assign mode_o         = mode_q;
  assign d_in_p_o       = d_in_p_q;
  assign d_in_w_o       = d_in_w_q;
  assign bit_valid_o    = bit_valid_q;
  assign result_o       = result_q;
  assign result_err_o   = result_err_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_bnn_host_loader.sv
// Testbench for bnn_host_loader. The reference model regenerates every
// expected serial bit from the random byte frame using plain bit arithmetic.
// It also checks the strobe count and timing, the handshakes and the result port.
module tb_bnn_host_loader;
  localparam int PIX_BITS = 784;
  localparam int WGT_BITS = 2320;
  localparam int TIMEOUT  = 16;
  localparam int PB = PIX_BITS / 8;
  localparam int WB = WGT_BITS / 8;

  logic       clk = 1'b0;
  logic       reset, start_i;
  logic [7:0] pix_data_i, wgt_data_i;
  logic       pix_valid_i, wgt_valid_i, pix_ready_o, wgt_ready_o;
  logic       busy_o, mode_o, d_in_p_o, d_in_w_o, bit_valid_o;
  logic [3:0] answer_i, result_o;
  logic       result_done_i, result_err_o, result_valid_o, result_ready_i;

  bnn_host_loader #(.PIX_BITS(PIX_BITS), .WGT_BITS(WGT_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .wgt_data_i(wgt_data_i), .wgt_valid_i(wgt_valid_i), .wgt_ready_o(wgt_ready_o),
    .busy_o(busy_o), .mode_o(mode_o), .d_in_p_o(d_in_p_o), .d_in_w_o(d_in_w_o),
    .bit_valid_o(bit_valid_o), .answer_i(answer_i), .result_done_i(result_done_i),
    .result_o(result_o), .result_err_o(result_err_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input bit ok, input string msg);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s", msg);
    end
  endtask

  byte unsigned pix_mem[PB+4];
  byte unsigned wgt_mem[WB+4];
  bit           got_p[WGT_BITS];
  bit           got_w[WGT_BITS];
  int           strobes, first_c, last_c, c0, pix_acc, wgt_acc;

  function automatic logic [12:0] outs();
    return {mode_o, busy_o, bit_valid_o, d_in_p_o, d_in_w_o, result_valid_o,
            result_err_o, result_o, pix_ready_o, wgt_ready_o};
  endfunction

  task automatic gen_frame();
    for (int i = 0; i < PB + 4; i++) pix_mem[i] = 8'($urandom);
    for (int i = 0; i < WB + 4; i++) wgt_mem[i] = 8'($urandom);
  endtask

  // Drive one frame and collect the strobes. stall_byte >= 0 starves the pixel
  // stream when that byte is requested. start_at >= 0 pulses start_i
  // mid-load. abort_at > 0 returns early once that many strobes have been seen.
  task automatic load_frame(input int stall_byte, input int start_at, input int abort_at);
    int pi, wi, stall_ready, hold_bad, bad, exp_gaps;
    bit pa, wa, lp, lw, exp_p, exp_w;
    byte unsigned t;
    strobes = 0; first_c = -1; last_c = -1; pix_acc = 0; wgt_acc = 0;
    pi = 0; wi = 0; stall_ready = 0; hold_bad = 0; lp = 0; lw = 0;
    @(posedge clk); #1;
    start_i = 1'b1; result_ready_i = 1'b0; result_done_i = 1'b0;
    pix_data_i = pix_mem[0]; pix_valid_i = 1'b1;
    wgt_data_i = wgt_mem[0]; wgt_valid_i = 1'b1;
    @(negedge clk); c0 = cyc;
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    check({mode_o, busy_o} === 2'b11,
          $sformatf("mode_after_start: got %b want 11", {mode_o, busy_o}));
    for (int k = 0; k < WGT_BITS + 100; k++) begin
      if (bit_valid_o) begin
        if (strobes < WGT_BITS) begin
          got_p[strobes] = d_in_p_o;
          got_w[strobes] = d_in_w_o;
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc; lp = d_in_p_o; lw = d_in_w_o;
        strobes++;
      end else if (first_c >= 0 && {d_in_p_o, d_in_w_o} !== {lp, lw}) begin
        hold_bad++;
      end
      if (abort_at > 0 && strobes == abort_at) return;
      if (strobes >= WGT_BITS) break;
      pa = pix_valid_i && pix_ready_o;
      wa = wgt_valid_i && wgt_ready_o;
      if (pi == stall_byte && pix_ready_o && !pix_valid_i) stall_ready++;
      @(posedge clk); #1;
      if (pa) begin pi++; pix_acc++; end
      if (wa) begin wi++; wgt_acc++; end
      start_i = (k == start_at);
      // The first request for the stalled byte arrives while the last bit of the
      // previous byte is still going out. So 6 unanswered requests give 5 starved cycles.
      pix_valid_i = !(pi == stall_byte && stall_ready < 6);
      pix_data_i  = pix_mem[pi];
      wgt_data_i  = wgt_mem[wi];
      @(negedge clk);
    end
    exp_gaps = (stall_byte >= 0) ? 5 : 0;
    check(strobes === WGT_BITS,
          $sformatf("strobe_count: got %0d want %0d", strobes, WGT_BITS));
    check(first_c === c0 + 2,
          $sformatf("first_strobe_cycle: got %0d want %0d", first_c - c0, 2));
    check(last_c - c0 === WGT_BITS + 1 + exp_gaps,
          $sformatf("last_strobe_cycle: got %0d want %0d", last_c - c0, WGT_BITS + 1 + exp_gaps));
    bad = 0;
    for (int b = 0; b < WGT_BITS; b++) begin
      t = pix_mem[b / 8];
      exp_p = (b < PIX_BITS) ? t[b % 8] : 1'b0;
      t = wgt_mem[b / 8];
      exp_w = t[b % 8];
      if (got_p[b] !== exp_p || got_w[b] !== exp_w) bad++;
    end
    check(bad == 0, $sformatf("serial_bits: got %0d wrong bits want 0", bad));
    check(hold_bad == 0, $sformatf("data_hold_on_stall: got %0d changes want 0", hold_bad));
    check(pix_acc === PB && wgt_acc === WB,
          $sformatf("bytes_accepted: got %0d/%0d want %0d/%0d", pix_acc, wgt_acc, PB, WB));
  endtask

  // Acceptance handshake, then the block must sit idle.
  task automatic accept_result(input bit with_start);
    int bad;
    @(posedge clk); #1; result_ready_i = 1'b1; start_i = with_start;
    @(posedge clk); #1; result_ready_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check({result_valid_o, mode_o, busy_o, result_err_o} === 4'b0000,
          $sformatf("after_accept: got %b want 0000",
                    {result_valid_o, mode_o, busy_o, result_err_o}));
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (busy_o || mode_o || bit_valid_o || pix_ready_o || wgt_ready_o) bad++;
    end
    check(bad == 0, $sformatf("stays_idle: got %0d busy cycles want 0", bad));
  endtask

  // Starts at the negedge of the last strobe. Done is raised 10 cycles later.
  task automatic wait_result(input logic [3:0] ans, input int hold, input bit start_on_accept);
    int bad;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!mode_o || result_valid_o || bit_valid_o || pix_ready_o || wgt_ready_o) bad++;
    end
    check(bad == 0, $sformatf("wait_state: got %0d bad cycles want 0", bad));
    @(posedge clk); #1; answer_i = ans; result_done_i = 1'b1;
    @(negedge clk);
    check(result_valid_o === 1'b0, $sformatf("valid_early: got %b want 0", result_valid_o));
    @(posedge clk); #1; result_done_i = 1'b0; answer_i = ~ans;
    @(negedge clk);
    check({result_valid_o, result_err_o, result_o, mode_o} === {1'b1, 1'b0, ans, 1'b1},
          $sformatf("result: got %b want %b", {result_valid_o, result_err_o, result_o, mode_o},
                    {1'b1, 1'b0, ans, 1'b1}));
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if ({result_valid_o, result_o, mode_o, busy_o} !== {1'b1, ans, 1'b1, 1'b1}) bad++;
    end
    check(bad == 0, $sformatf("result_hold: got %0d unstable cycles want 0", bad));
    accept_result(start_on_accept);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(outs() === 13'd0, $sformatf("reset_outputs: got %h want 0", outs()));
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check(outs() === 13'd0, $sformatf("idle_after_reset: got %h want 0", outs()));
  endtask

  task automatic test_basic();
    gen_frame();
    load_frame(-1, -1, -1);
    wait_result(4'h7, 0, 1'b0);
  endtask

  task automatic test_stall();
    gen_frame();
    load_frame(3, -1, -1);
    wait_result(4'($urandom), 0, 1'b0);
  endtask

  task automatic test_result_hold();
    gen_frame();
    load_frame(-1, -1, -1);
    wait_result(4'($urandom), 20, 1'b0);
  endtask

  task automatic test_reset_mid();
    gen_frame();
    load_frame(-1, -1, 1000);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check(outs() === 13'd0, $sformatf("reset_mid_frame: got %h want 0", outs()));
    gen_frame();
    load_frame(-1, -1, -1);
    wait_result(4'($urandom), 2, 1'b0);
  endtask

  task automatic test_ignore_start();
    gen_frame();
    load_frame(-1, 500, -1);
    wait_result(4'($urandom), 3, 1'b1);
  endtask

`ifdef BNN_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    gen_frame();
    load_frame(-1, -1, -1);
    seen = -1;
    for (int k = 0; k < 4 * TIMEOUT; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (result_valid_o) begin seen = cyc; break; end
    end
    check(seen - last_c === TIMEOUT,
          $sformatf("timeout_latency: got %0d want %0d", seen - last_c, TIMEOUT));
    check({result_valid_o, result_err_o, result_o} === {1'b1, 1'b1, 4'hF},
          $sformatf("timeout_result: got %b want 111111", {result_valid_o, result_err_o, result_o}));
    accept_result(1'b0);
  endtask
`endif

  initial begin
    reset = 1'b1; start_i = 1'b0; pix_data_i = '0; pix_valid_i = 1'b0;
    wgt_data_i = '0; wgt_valid_i = 1'b0; answer_i = '0;
    result_done_i = 1'b0; result_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_result_hold();
    test_reset_mid();
    test_ignore_start();
`ifdef BNN_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
